mc10415_array: RTL and testbench
================================

# mc10415_array

Parametrised synchronous successor to the single-bit MC10415 RAM model: a DEPTH x WIDTH array with per-bit write mask, optional even parity, and a hardware clear sequencer that zeroes every word after reset. It backs the wider scratchpad and fast-memory arrays, where multiple 10415-class packages were previously ganged by hand. Disabled and writing outputs read as zero, preserving the ECL wired-OR convention the surrounding datapath relies on.

## Interface
- WIDTH, 8: data bits per word (1..64).
- DEPTH, 1024: words; power of two, 2..4096.
- PARITY, 1: 1 = store and check one even-parity bit per word; 0 = no parity, perr tied 0.
- AW, $clog2(DEPTH): address width, derived, not overridden.

- clk  in  1  single clock; all state changes on rising edge.
- nreset  in  1  synchronous, active-low reset; sampled on clk rising edge.
- addr  in  AW  word address.
- d  in  WIDTH  write data.
- wmask  in  WIDTH  per-bit write enable; 1 = bit written.
- nen  in  1  active-low chip enable.
- nwrite  in  1  active-low write strobe; effective only with nen=0.
- q  out  WIDTH  registered read data.
- perr  out  1  registered parity error for the word in q.
- busy  out  1  clear sequencer running; accesses ignored.

## Operation
- Access decode per cycle, when busy=0: cs = !nen; we = cs & !nwrite.
- Read (cs & !we): q <= ram[addr]; perr <= PARITY & (stored parity != ^ram[addr]).
- Write (we): ram[addr] <= (old & ~wmask) | (d & wmask); stored parity <= ^merged word; q <= 0; perr <= 0. wmask=0 leaves the word and parity unchanged.
- Deselected (!cs): q <= 0, perr <= 0; array unchanged.
- Clear sequencer, two states:
  - CLEAR: ram[ctr] <= 0, parity[ctr] <= 0, ctr <= ctr+1; at ctr == DEPTH-1 go to IDLE.
  - IDLE: normal access.
- busy = (state == CLEAR). During CLEAR, addr, d, wmask, nen and nwrite are ignored; q and perr are held 0.
- ctr is AW bits wide and wraps to 0 on leaving CLEAR. It is not externally visible.

## Timing
- Reset, with nreset=0 at an edge: state <= CLEAR, ctr <= 0, q <= 0, perr <= 0, busy = 1. The array is not touched while reset is held.
- After release, the first edge with nreset=1 clears word 0. The edge that clears word DEPTH-1 moves to IDLE. busy falls after exactly DEPTH edges with nreset=1.
- Reset reasserted mid-clear restarts the clear from word 0. Reset during IDLE re-enters CLEAR, so contents are lost.
- Read latency is 1: addr presented at edge N, and data appears on q after edge N, valid through edge N+1. Back-to-back reads to any addresses are sustained every cycle.
- Write takes effect at the edge. A read of the same address on the next cycle returns the new data.
- q is 0 in the cycle after a write; there is no write-through.
- Address changes with nen=1 have no effect.
- The first access is accepted at the first edge where busy=0.

## Test plan
- Reset then clear: DEPTH=16, WIDTH=8. Hold nreset=0 for 3 cycles, then release. busy=1 for exactly 16 cycles then 0. Reads of all 16 addresses return q=0x00, perr=0.
- Write/read: write d=0xA5, wmask=0xFF to addr 3, then read addr 3. The write cycle gives q=0x00; the next read gives q=0xA5, perr=0. A deselected cycle gives q=0x00.
- Masked merge: write 0xFF to addr 5, then write d=0x00 with wmask=0x0F, then read. q=0xF0, perr=0. Then write with wmask=0x00 and read: q still 0xF0.
- Parity: PARITY=1. Force-flip one stored bit of addr 7 (which holds 0x3C) via hierarchical access, then read. perr=1, q=0x3D or the equivalent flipped value. With PARITY=0, the same flip gives perr=0.
- Reset mid-clear: DEPTH=16. Write 0x11 to addr 10, then pulse nreset=0 for 1 cycle. Pulse again at busy cycle 5. busy lasts 16 cycles after the final release, and a read of addr 10 returns 0x00.
- Access during busy: drive a write of 0x77 to addr 2 while busy=1. It is ignored; after busy falls, a read of addr 2 returns 0x00.

Source files
------------

// File: rtl/mc10415_array.sv
// ============================================================================
// Module   : mc10415_array
// Purpose  : Synchronous DEPTH x WIDTH RAM array with per-bit write mask,
//            optional even parity per word, and a clear sequencer that zeroes
//            every word after reset. A disabled or writing access drives q
//            to zero, so several arrays can be OR-ed onto a shared bus.
// Ports    : clk     - clock; all state changes on the rising edge
//            nreset  - synchronous active-low reset
//            addr    - word address (AW bits)
//            d       - write data (WIDTH bits)
//            wmask   - per-bit write enable, 1 = bit written
//            nen     - active-low chip enable
//            nwrite  - active-low write strobe (needs nen = 0)
//            q       - registered read data, 0 when not reading
//            perr    - registered parity error for the word in q
//            busy    - clear sequencer running; accesses are ignored
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc10415_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1024,
    parameter int PARITY = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] wmask,
    input  logic             nen,
    input  logic             nwrite,
    output logic [WIDTH-1:0] q,
    output logic             perr,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Sequencer state encoding
    // ------------------------------------------------------------------
    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [AW-1:0]    r_ctr;
    logic [WIDTH-1:0] r_q;
    logic             r_perr;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_busy;
    logic             w_cs;
    logic             w_we;
    logic             w_rd;
    logic             w_mask_any;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_merged;
    logic             w_perr_rd;

    // ------------------------------------------------------------------
    // Access decode; the bus is ignored entirely while clearing
    // ------------------------------------------------------------------
    assign w_busy     = (r_state == c_ST_CLEAR);
    assign w_cs       = ~nen & ~w_busy;
    assign w_we       = w_cs & ~nwrite;
    assign w_rd       = w_cs & nwrite;
    assign w_mask_any = |wmask;

    assign w_rdata    = r_mem[addr];
    assign w_merged   = (w_rdata & ~wmask) | (d & wmask);

    // ------------------------------------------------------------------
    // Clear sequencer and registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= c_ST_CLEAR;
            r_ctr   <= '0;
            r_q     <= '0;
            r_perr  <= 1'b0;
        end else if (r_state == c_ST_CLEAR) begin
            r_q    <= '0;
            r_perr <= 1'b0;
            if (r_ctr == c_LAST) begin
                r_state <= c_ST_IDLE;
                r_ctr   <= '0;
            end else begin
                r_ctr <= r_ctr + AW'(1);
            end
        end else begin
            // Writes and deselected cycles return zero (no write-through)
            if (w_rd) begin
                r_q    <= w_rdata;
                r_perr <= w_perr_rd;
            end else begin
                r_q    <= '0;
                r_perr <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data array. No reset term on the storage itself: reset only restarts
    // the sequencer, which then zeroes one word per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nreset) begin
            if (w_busy) begin
                r_mem[r_ctr] <= '0;
            end else if (w_we && w_mask_any) begin
                r_mem[addr] <= w_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional parity plane. An all-zero mask must not touch the stored
    // parity, otherwise it would silently repair a corrupted word.
    // ------------------------------------------------------------------
    generate
        if (PARITY != 0) begin : g_parity
            logic r_par [DEPTH];

            always_ff @(posedge clk) begin
                if (nreset) begin
                    if (w_busy) begin
                        r_par[r_ctr] <= 1'b0;
                    end else if (w_we && w_mask_any) begin
                        r_par[addr] <= ^w_merged;
                    end
                end
            end

            assign w_perr_rd = r_par[addr] ^ (^w_rdata);
        end else begin : g_no_parity
            assign w_perr_rd = 1'b0;
        end
    endgenerate

    assign q    = r_q;
    assign perr = r_perr;
    assign busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_mc10415_array.sv
// ============================================================================
// Module   : tb_mc10415_array
// Purpose  : Self-checking bench for mc10415_array. Two instances (parity on
//            and parity off) share one stimulus stream and are compared
//            against a word-level array model kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc10415_array;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             nreset;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] wmask;
    logic             nen;
    logic             nwrite;
    logic [WIDTH-1:0] q_p,  q_n;
    logic             perr_p, perr_n;
    logic             busy_p, busy_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word contents and the parity bit stored with each word
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_par [DEPTH];

    mc10415_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PARITY(1)) dut (
        .clk(clk), .nreset(nreset), .addr(addr), .d(d), .wmask(wmask),
        .nen(nen), .nwrite(nwrite), .q(q_p), .perr(perr_p), .busy(busy_p)
    );

    mc10415_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PARITY(0)) dut_np (
        .clk(clk), .nreset(nreset), .addr(addr), .d(d), .wmask(wmask),
        .nen(nen), .nwrite(nwrite), .q(q_n), .perr(perr_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_par[i] = 1'b0;
        end
    endtask

    task automatic model_write(input int a, input logic [WIDTH-1:0] wd,
                               input logic [WIDTH-1:0] wm);
        if (wm != '0) begin
            m_mem[a] = (m_mem[a] & ~wm) | (wd & wm);
            m_par[a] = ^m_mem[a];
        end
    endtask

    task automatic drive_idle;
        nen = 1'b1; nwrite = 1'b1; addr = '0; d = '0; wmask = '0;
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] wd,
                            input logic [WIDTH-1:0] wm);
        nen = 1'b0; nwrite = 1'b0; addr = AW'(a); d = wd; wmask = wm;
        tick();
        model_write(a, wd, wm);
    endtask

    task automatic do_read(input int a);
        nen = 1'b0; nwrite = 1'b1; addr = AW'(a); d = '0; wmask = '0;
        tick();
    endtask

    // Counts edges with nreset=1 until busy drops, bounded
    task automatic wait_clear(output int edges);
        edges = 0;
        while (busy_p && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset;
        int edges;
        drive_idle();
        nreset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy_p !== 1'b1 || q_p !== '0 || perr_p !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b q=%h perr=%b expected busy=1 q=00 perr=0",
                     busy_p, q_p, perr_p);
        end
        nreset = 1'b1;
        wait_clear(edges);
        model_clear();
        n_checks++;
        if (edges != DEPTH) begin
            n_errors++;
            $display("FAIL clear_length: busy edges=%0d expected %0d", edges, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a);
            n_checks++;
            if (q_p !== 8'h00 || perr_p !== 1'b0 || q_n !== 8'h00) begin
                n_errors++;
                $display("FAIL cleared_word[%0d]: q=%h perr=%b q_np=%h expected 00 0 00",
                         a, q_p, perr_p, q_n);
            end
        end
    endtask

    task automatic test_write_read;
        do_write(3, 8'hA5, 8'hFF);
        n_checks++;
        if (q_p !== 8'h00) begin
            n_errors++;
            $display("FAIL write_cycle_q: q=%h expected 00", q_p);
        end
        do_read(3);
        n_checks++;
        if (q_p !== m_mem[3] || perr_p !== 1'b0 || q_n !== m_mem[3]) begin
            n_errors++;
            $display("FAIL read_after_write: q=%h perr=%b q_np=%h expected %h 0",
                     q_p, perr_p, q_n, m_mem[3]);
        end
        drive_idle();
        addr = 4'd3;
        tick();
        n_checks++;
        if (q_p !== 8'h00 || q_n !== 8'h00) begin
            n_errors++;
            $display("FAIL deselected_q: q=%h q_np=%h expected 00", q_p, q_n);
        end
    endtask

    task automatic test_masked_merge;
        do_write(5, 8'hFF, 8'hFF);
        do_write(5, 8'h00, 8'h0F);
        do_read(5);
        n_checks++;
        if (q_p !== 8'hF0 || perr_p !== 1'b0) begin
            n_errors++;
            $display("FAIL masked_merge: q=%h perr=%b expected f0 0", q_p, perr_p);
        end
        do_write(5, 8'h5A, 8'h00);
        do_read(5);
        n_checks++;
        if (q_p !== 8'hF0 || perr_p !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_mask: q=%h perr=%b expected f0 0", q_p, perr_p);
        end
    endtask

    task automatic test_parity;
        do_write(7, 8'h3C, 8'hFF);
        drive_idle();
        tick();
        // Corrupt one data bit behind the array's back; stored parity is kept
        dut.r_mem[7][0]    = ~dut.r_mem[7][0];
        dut_np.r_mem[7][0] = ~dut_np.r_mem[7][0];
        m_mem[7] = m_mem[7] ^ 8'h01;
        do_read(7);
        n_checks++;
        if (q_p !== 8'h3D || perr_p !== 1'b1) begin
            n_errors++;
            $display("FAIL parity_flip: q=%h perr=%b expected 3d 1", q_p, perr_p);
        end
        n_checks++;
        if (q_n !== 8'h3D || perr_n !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_off_flip: q=%h perr=%b expected 3d 0", q_n, perr_n);
        end
        // An all-zero mask must not repair the stored parity
        do_write(7, 8'hFF, 8'h00);
        do_read(7);
        n_checks++;
        if (perr_p !== (m_par[7] ^ (^m_mem[7]))) begin
            n_errors++;
            $display("FAIL parity_zero_mask: perr=%b expected %b",
                     perr_p, m_par[7] ^ (^m_mem[7]));
        end
        do_write(7, 8'h3C, 8'hFF);
        do_read(7);
        n_checks++;
        if (q_p !== 8'h3C || perr_p !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_rewrite: q=%h perr=%b expected 3c 0", q_p, perr_p);
        end
    endtask

    task automatic test_reset_mid_clear;
        int edges;
        do_write(10, 8'h11, 8'hFF);
        drive_idle();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (busy_p !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_mid_clear: busy=%b expected 1", busy_p);
        end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        wait_clear(edges);
        model_clear();
        n_checks++;
        if (edges != DEPTH) begin
            n_errors++;
            $display("FAIL restart_clear_length: busy edges=%0d expected %0d", edges, DEPTH);
        end
        do_read(10);
        n_checks++;
        if (q_p !== 8'h00 || perr_p !== 1'b0) begin
            n_errors++;
            $display("FAIL cleared_after_restart: q=%h perr=%b expected 00 0", q_p, perr_p);
        end
    endtask

    task automatic test_access_during_busy;
        int edges;
        drive_idle();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        nen = 1'b0; nwrite = 1'b0; addr = 4'd2; d = 8'h77; wmask = 8'hFF;
        edges = 0;
        while (busy_p && edges < 200) begin
            tick();
            edges++;
            n_checks++;
            if (q_p !== 8'h00 || perr_p !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_outputs: q=%h perr=%b expected 00 0", q_p, perr_p);
            end
        end
        model_clear();
        n_checks++;
        if (edges != DEPTH) begin
            n_errors++;
            $display("FAIL busy_access_clear_length: edges=%0d expected %0d", edges, DEPTH);
        end
        do_read(2);
        n_checks++;
        if (q_p !== 8'h00) begin
            n_errors++;
            $display("FAIL write_ignored_while_busy: q=%h expected 00", q_p);
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] exp_q;
        logic             exp_perr;
        for (int i = 0; i < 400; i++) begin
            int a;
            a      = int'($urandom_range(0, DEPTH - 1));
            addr   = AW'(a);
            d      = WIDTH'($urandom);
            wmask  = ($urandom_range(0, 3) == 0) ? 8'hFF : WIDTH'($urandom);
            nen    = ($urandom_range(0, 4) == 0);
            nwrite = ($urandom_range(0, 1) == 0);
            tick();
            if (nen) begin
                exp_q = '0; exp_perr = 1'b0;
            end else if (!nwrite) begin
                exp_q = '0; exp_perr = 1'b0;
                model_write(a, d, wmask);
            end else begin
                exp_q    = m_mem[a];
                exp_perr = m_par[a] ^ (^m_mem[a]);
            end
            n_checks++;
            if (q_p !== exp_q || perr_p !== exp_perr || q_n !== exp_q || perr_n !== 1'b0) begin
                n_errors++;
                $display("FAIL random[%0d] addr=%0d: q=%h perr=%b q_np=%h perr_np=%b expected q=%h perr=%b/0",
                         i, a, q_p, perr_p, q_n, perr_n, exp_q, exp_perr);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int a = 0; a < DEPTH; a++) do_write(a, WIDTH'(a * 37 + 5), 8'hFF);
        for (int a = DEPTH - 1; a >= 0; a--) begin
            do_read(a);
            n_checks++;
            if (q_p !== m_mem[a] || perr_p !== 1'b0) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: q=%h perr=%b expected %h 0",
                         a, q_p, perr_p, m_mem[a]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write_read();
        test_masked_merge();
        test_parity();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        test_access_during_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
